// File: rtl/alarm_trigger_pkg.sv
// rtl/alarm_trigger_pkg.sv - shared state encoding, time field widths and limits for alarm_trigger
package alarm_trigger_pkg;

    // 2'b11 is not a legal state; the FSM decodes it back to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RING   = 2'b01,
        ST_SNOOZE = 2'b10
    } state_e;

    localparam int HOUR_W   = 5;
    localparam int MIN_W    = 6;
    localparam int SEC_W    = 6;
    localparam int HOUR_MAX = 23;
    localparam int MIN_MAX  = 59;

    // A requested alarm time is accepted only when both fields are in range.
    function automatic logic alarm_time_valid(input logic [HOUR_W-1:0] h,
                                              input logic [MIN_W-1:0]  m);
        return (h <= HOUR_W'(HOUR_MAX)) && (m <= MIN_W'(MIN_MAX));
    endfunction

endpackage

// File: rtl/alarm_trigger_if.sv
// rtl/alarm_trigger_if.sv - time/control inputs and trig/status outputs of alarm_trigger
//   master: drives tick, time of day, enables, alarm load, snooze/stop; observes outputs
//   slave : the alarm_trigger block itself
interface alarm_trigger_if;
    import alarm_trigger_pkg::*;

    logic              tick;
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
    logic [SEC_W-1:0]  sec;
    logic              alarm_en;
    logic              chime_en;
    logic              set_alarm;
    logic [HOUR_W-1:0] alarm_hour_in;
    logic [MIN_W-1:0]  alarm_min_in;
    logic              snooze;
    logic              stop;
    logic              trig;
    logic              ringing;
    logic              snoozing;
    logic [HOUR_W-1:0] alarm_hour;
    logic [MIN_W-1:0]  alarm_min;

    modport master (
        output tick, hour, min, sec, alarm_en, chime_en, set_alarm,
               alarm_hour_in, alarm_min_in, snooze, stop,
        input  trig, ringing, snoozing, alarm_hour, alarm_min
    );

    modport slave (
        input  tick, hour, min, sec, alarm_en, chime_en, set_alarm,
               alarm_hour_in, alarm_min_in, snooze, stop,
        output trig, ringing, snoozing, alarm_hour, alarm_min
    );

endinterface

// File: rtl/alarm_tick_timer.sv
// rtl/alarm_tick_timer.sv - loadable down-counter stepped by the 1 Hz tick
//   clk, rst   : clock, synchronous active-high reset
//   load_i     : load load_val_i on the next edge (wins over tick_i)
//   load_val_i : value to load
//   tick_i     : decrement enable
//   done_o     : this tick takes the count to zero
module alarm_tick_timer #(
    parameter int CW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    input  logic          tick_i,
    output logic          done_o
);

    logic [CW-1:0] count_q, count_d;

    // Expiry is flagged on the tick that moves 1 -> 0 so the owner can reload
    // in the same cycle; an idle counter parked at 0 never wraps.
    assign done_o = tick_i && (count_q == CW'(1));

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (tick_i && (count_q != '0)) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/alarm_trigger.sv
// rtl/alarm_trigger.sv - alarm/snooze/chime sequencer emitting one-cycle trig pulses for Flash
//   clk, rst : clock, synchronous active-high reset
//   bus      : alarm_trigger_if.slave (time of day, enables, alarm load, snooze/stop in;
//              trig, ringing, snoozing, stored alarm time out)
module alarm_trigger
    import alarm_trigger_pkg::*;
#(
    parameter int RING_PERIOD  = 4,
    parameter int RING_TIMEOUT = 60,
    parameter int SNOOZE_SEC   = 300,
    parameter int CW           = 9
) (
    input  logic             clk,
    input  logic             rst,
    alarm_trigger_if.slave   bus
);

    state_e            state_q, state_d;
    logic              trig_q, trig_d, trig_evt;
    logic              ringing_q, ringing_d;
    logic              snoozing_q, snoozing_d;
    logic [HOUR_W-1:0] alarm_hour_q, alarm_hour_d;
    logic [MIN_W-1:0]  alarm_min_q, alarm_min_d;

    logic              match, chime;
    logic              pc_load, pc_tick, pc_done;
    logic              tc_load, tc_tick, tc_done;
    logic [CW-1:0]     tc_val;

    assign match = bus.tick && bus.alarm_en && (bus.hour == alarm_hour_q)
                   && (bus.min == alarm_min_q) && (bus.sec == '0);
    assign chime = bus.tick && bus.chime_en && (bus.min == '0) && (bus.sec == '0);

    // Period counter: spacing of trig pulses while ringing.
    alarm_tick_timer #(.CW(CW)) u_period (
        .clk        (clk),
        .rst        (rst),
        .load_i     (pc_load),
        .load_val_i (CW'(RING_PERIOD)),
        .tick_i     (pc_tick),
        .done_o     (pc_done)
    );

    // Shared counter: ring timeout in RING, snooze length in SNOOZE.
    alarm_tick_timer #(.CW(CW)) u_session (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tc_load),
        .load_val_i (tc_val),
        .tick_i     (tc_tick),
        .done_o     (tc_done)
    );

    always_comb begin
        state_d  = state_q;
        trig_evt = 1'b0;
        pc_load  = 1'b0;
        pc_tick  = 1'b0;
        tc_load  = 1'b0;
        tc_tick  = 1'b0;
        tc_val   = CW'(RING_TIMEOUT);
        case (state_q)
            ST_IDLE: begin
                if (match) begin
                    state_d  = ST_RING;
                    trig_evt = 1'b1;
                    pc_load  = 1'b1;
                    tc_load  = 1'b1;
                end else if (chime) begin
                    trig_evt = 1'b1;
                end
            end
            ST_RING: begin
                // Counters only see the tick when no user action claims the cycle.
                if (!bus.alarm_en || bus.stop) begin
                    state_d = ST_IDLE;
                end else if (bus.snooze) begin
                    state_d = ST_SNOOZE;
                    tc_load = 1'b1;
                    tc_val  = CW'(SNOOZE_SEC);
                end else begin
                    pc_tick = bus.tick;
                    tc_tick = bus.tick;
                    if (tc_done) begin
                        state_d = ST_IDLE;
                    end else if (pc_done) begin
                        trig_evt = 1'b1;
                        pc_load  = 1'b1;
                    end
                end
            end
            ST_SNOOZE: begin
                if (!bus.alarm_en || bus.stop) begin
                    state_d = ST_IDLE;
                end else begin
                    tc_tick = bus.tick;
                    if (tc_done) begin
                        state_d  = ST_RING;
                        trig_evt = 1'b1;
                        pc_load  = 1'b1;
                        tc_load  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign trig_d      = trig_evt && !trig_q;
    assign ringing_d   = (state_d == ST_RING);
    assign snoozing_d  = (state_d == ST_SNOOZE);
    assign alarm_hour_d = (bus.set_alarm && alarm_time_valid(bus.alarm_hour_in, bus.alarm_min_in))
                          ? bus.alarm_hour_in : alarm_hour_q;
    assign alarm_min_d  = (bus.set_alarm && alarm_time_valid(bus.alarm_hour_in, bus.alarm_min_in))
                          ? bus.alarm_min_in : alarm_min_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            trig_q       <= 1'b0;
            ringing_q    <= 1'b0;
            snoozing_q   <= 1'b0;
            alarm_hour_q <= '0;
            alarm_min_q  <= '0;
        end else begin
            state_q      <= state_d;
            trig_q       <= trig_d;
            ringing_q    <= ringing_d;
            snoozing_q   <= snoozing_d;
            alarm_hour_q <= alarm_hour_d;
            alarm_min_q  <= alarm_min_d;
        end
    end

    assign bus.trig       = trig_q;
    assign bus.ringing    = ringing_q;
    assign bus.snoozing   = snoozing_q;
    assign bus.alarm_hour = alarm_hour_q;
    assign bus.alarm_min  = alarm_min_q;

endmodule

// File: doc/alarm_trigger.md
Name: alarm_trigger

Overview:
- Upstream stage of the Beep flash/beeper block in the digital clock.
- Watches the running time of day and a programmable alarm time, then runs the alarm session: ringing, snooze and stop.
- Emits single-cycle `trig` pulses; each pulse starts one flash/beep sequence in the downstream Flash block.
- Also generates an optional hourly chime pulse.

Parameters:
- RING_PERIOD, 4: seconds (ticks) between successive `trig` pulses while ringing; must be ≥1.
- RING_TIMEOUT, 60: seconds of ringing without user action before auto-stop to IDLE.
- SNOOZE_SEC, 300: seconds spent in SNOOZE before re-ringing.
- CW, 9: width of the internal tick counter; must hold max(RING_TIMEOUT, SNOOZE_SEC).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- tick  in  1  one-cycle 1 Hz enable, asserted in the same cycle the time inputs show the new second.
- hour  in  5  current hour, binary 0..23.
- min  in  6  current minute, binary 0..59.
- sec  in  6  current second, binary 0..59.
- alarm_en  in  1  alarm armed (level).
- chime_en  in  1  hourly chime enabled (level).
- set_alarm  in  1  one-cycle load strobe for the alarm time.
- alarm_hour_in  in  5  alarm hour to load.
- alarm_min_in  in  6  alarm minute to load.
- snooze  in  1  one-cycle snooze request (already debounced).
- stop  in  1  one-cycle stop request (already debounced).
- trig  out  1  one-cycle pulse; drives Flash `in`.
- ringing  out  1  high in RING.
- snoozing  out  1  high in SNOOZE.
- alarm_hour  out  5  stored alarm hour.
- alarm_min  out  6  stored alarm minute.

Behaviour:
- Clock and reset: one clock domain, clk; rst is synchronous and active-high.
- Reset values:
  - state = IDLE; trig = 0; ringing = 0; snoozing = 0.
  - alarm_hour = 0; alarm_min = 0; counters = 0.
  - A reset asserted mid-ring or mid-snooze aborts immediately; no trig in the reset cycle or the cycle after.
- Alarm load:
  - On set_alarm, registers load on the next edge, in any state.
  - A load with alarm_hour_in > 23 or alarm_min_in > 59 is ignored entirely; both registers keep their values.
  - A load does not change the current state.
- Match: match = tick & alarm_en & hour==alarm_hour & min==alarm_min & sec==0.
- Chime: chime = tick & chime_en & min==0 & sec==0.
- trig is registered, so it appears one cycle after the causing tick or event.
- IDLE:
  - match → RING; trig pulses; period counter loads RING_PERIOD; timeout counter loads RING_TIMEOUT.
  - else chime → single trig, stay in IDLE.
  - match and chime together → exactly one trig.
- RING:
  - On each tick, both counters decrement.
  - Period counter reaching 0 → trig pulses and the period counter reloads.
  - Timeout counter reaching 0 → IDLE; no trig on that tick.
  - snooze → SNOOZE; counter loads SNOOZE_SEC; no trig.
  - stop → IDLE.
  - Chime and match are ignored.
- SNOOZE:
  - Counter decrements on tick; reaching 0 → RING, with a fresh trig and both ring counters reloaded.
  - stop → IDLE. snooze is ignored. Match and chime are ignored.
- Priorities, highest first: rst > alarm_en low (in RING/SNOOZE: forced to IDLE next edge, no trig) > stop > snooze > tick-driven events.
- Simultaneous stop and snooze → IDLE.
- A snooze or stop arriving in the same cycle as a tick wins; the tick's counter action is discarded.
- trig is never high two consecutive cycles.
- Outputs are all registered:
  - ringing = (state==RING); snoozing = (state==SNOOZE).
- Counters are unsigned CW-bit, never underflow (load on the 0 transition), and only change on tick or load.
- Time inputs are used only when tick=1.

Decomposition:
- Shared package holds:
  - State encoding: IDLE = 2'b00, RING = 2'b01, SNOOZE = 2'b10; 2'b11 is illegal and decodes to IDLE next cycle.
  - Time field widths: HOUR_W = 5, MIN_W = 6, SEC_W = 6.
  - Limits: HOUR_MAX = 23, MIN_MAX = 59.
- One sub-module: alarm_tick_timer.
  - Ports: load, load value, tick enable, and a done flag (count == 0 on tick).
  - Instantiated twice: period counter, and shared timeout/snooze counter.

Test Plan:
- rst, set_alarm with 07:30, alarm_en = 1; drive tick at 07:30:00 → trig 1 cycle after the tick, ringing = 1; further trigs at 07:30:04, :08 and so on; ringing falls at 07:31:00 (60 ticks) with no trig on that tick.
- Ringing, snooze pulse at 07:30:10 → snoozing = 1, no trig; 300 ticks later (07:35:10) → trig, ringing = 1; stop → IDLE, no further trig.
- chime_en = 1, alarm 00:00 disabled; tick at 09:00:00 → exactly one trig; alarm 09:00 enabled, same tick → one trig, RING entered.
- set_alarm with hour = 24, min = 10 → alarm_hour/alarm_min unchanged; set_alarm during RING → regs update, ringing stays 1.
- stop and snooze in the same cycle while ringing → IDLE; snooze coincident with a period-expiry tick → SNOOZE, no trig.
- rst or alarm_en deasserted mid-RING and mid-SNOOZE → IDLE next edge, all outputs reset values, no trig for ≥2 cycles; check trig is never high two consecutive cycles.
